// File: rtl/logisim_counter_bank.sv
// Bank of independent up/down counters with a shared terminal mode,
// runtime terminal values, optional cascading, pulse and sticky overflow flags.
module logisim_counter_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int CASCADE  = 0
) (
    input  logic                      GlobalClock,
    input  logic                      clear_n,
    input  logic                      ClockEnable,
    input  logic [CHANNELS-1:0]       Enable,
    input  logic [CHANNELS-1:0]       Up_n_Down,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] LoadData,
    input  logic [CHANNELS*WIDTH-1:0] MaxVal,
    input  logic [CHANNELS-1:0]       ovf_clr,
    output logic [CHANNELS*WIDTH-1:0] CountValue,
    output logic [CHANNELS-1:0]       CompareOut,
    output logic [CHANNELS-1:0]       WrapPulse,
    output logic [CHANNELS-1:0]       Overflow
);

    typedef enum logic [1:0] {
        M_WRAP   = 2'd0,
        M_HALT   = 2'd1,
        M_CONT   = 2'd2,
        M_RELOAD = 2'd3
    } mode_t;

    localparam mode_t            TERM_MODE = mode_t'(MODE[1:0]);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [CHANNELS*WIDTH-1:0] count_next;
    logic [CHANNELS-1:0]       term;
    logic [WIDTH-1:0]          cur;
    logic [WIDTH-1:0]          lim;
    logic [WIDTH-1:0]          step;
    logic                      adv;
    logic                      chain;

    always_comb begin
        count_next = CountValue;
        CompareOut = '0;
        term       = '0;
        cur        = '0;
        lim        = '0;
        step       = '0;
        adv        = 1'b0;
        chain      = 1'b1;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cur  = CountValue[k*WIDTH +: WIDTH];
            lim  = MaxVal[k*WIDTH +: WIDTH];
            step = Up_n_Down[k] ? cur + ONE : cur - ONE;
            CompareOut[k] = Up_n_Down[k] ? (cur == lim) : (cur == '0);
            // chain carries the previous channel's terminal event down the cascade
            adv     = ClockEnable & Enable[k] & ((CASCADE != 0) ? chain : 1'b1) & ~load[k];
            term[k] = adv & CompareOut[k] & (TERM_MODE != M_HALT);
            chain   = term[k];
            if (ClockEnable & load[k]) begin
                count_next[k*WIDTH +: WIDTH] = LoadData[k*WIDTH +: WIDTH];
            end else if (adv) begin
                if (!CompareOut[k]) begin
                    count_next[k*WIDTH +: WIDTH] = step;
                end else begin
                    case (TERM_MODE)
                        M_WRAP:  count_next[k*WIDTH +: WIDTH] = Up_n_Down[k] ? '0 : lim;
                        M_HALT:  count_next[k*WIDTH +: WIDTH] = cur;
                        M_CONT:  count_next[k*WIDTH +: WIDTH] = step;
                        default: count_next[k*WIDTH +: WIDTH] = LoadData[k*WIDTH +: WIDTH];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge GlobalClock or negedge clear_n) begin
        if (!clear_n) begin
            CountValue <= '0;
            WrapPulse  <= '0;
            Overflow   <= '0;
        end else begin
            CountValue <= count_next;
            WrapPulse  <= term;
            Overflow   <= term | (Overflow & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_logisim_counter_bank.sv
// Self-checking bench: five counter banks (modes 0..3, plus a cascaded mode-0 bank)
// share stimulus and are compared against a behavioural model.
module tb_logisim_counter_bank;

    localparam int W  = 4;
    localparam int CH = 4;
    localparam int NI = 5;

    logic            clk = 1'b0;
    logic            clear_n;
    logic            ce;
    logic [CH-1:0]   en, up, ld, oclr;
    logic [CH*W-1:0] ldata, maxv;
    logic [CH*W-1:0] cv [NI];
    logic [CH-1:0]   co [NI];
    logic [CH-1:0]   wp [NI];
    logic [CH-1:0]   ov [NI];

    int  m_cnt [NI][CH];
    bit  m_wp  [NI][CH];
    bit  m_ov  [NI][CH];
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logisim_counter_bank #(
            .WIDTH   (W),
            .CHANNELS(CH),
            .MODE    ((g < 4) ? g : 0),
            .CASCADE ((g == 4) ? 1 : 0)
        ) u_dut (
            .GlobalClock(clk),
            .clear_n    (clear_n),
            .ClockEnable(ce),
            .Enable     (en),
            .Up_n_Down  (up),
            .load       (ld),
            .LoadData   (ldata),
            .MaxVal     (maxv),
            .ovf_clr    (oclr),
            .CountValue (cv[g]),
            .CompareOut (co[g]),
            .WrapPulse  (wp[g]),
            .Overflow   (ov[g])
        );
    end

    function automatic int mode_of(int i);
        return (i < 4) ? i : 0;
    endfunction

    function automatic bit exp_cmp(int i, int k);
        return up[k] ? (m_cnt[i][k] == int'(maxv[k*W +: W])) : (m_cnt[i][k] == 0);
    endfunction

    function automatic int got_cnt(int i, int k);
        return int'(cv[i][k*W +: W]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < CH; k++) begin
                m_cnt[i][k] = 0;
                m_wp[i][k]  = 0;
                m_ov[i][k]  = 0;
            end
    endtask

    // Advance one clock: work out every channel's next state from the counting
    // rules, wait for the edge, then commit it. Leaves time at posedge+1.
    task automatic cycle();
        int nc [NI][CH];
        bit nw [NI][CH];
        bit no [NI][CH];
        for (int i = 0; i < NI; i++) begin
            bit prev_term = 1;
            for (int k = 0; k < CH; k++) begin
                int  c     = m_cnt[i][k];
                int  mx    = int'(maxv[k*W +: W]);
                bit  hit   = exp_cmp(i, k);
                bit  gated = (i == 4 && k > 0) ? prev_term : 1'b1;
                bit  moves = ce && en[k] && gated && !ld[k];
                int  delta = up[k] ? 1 : 15;
                bit  fired = moves && hit && (mode_of(i) != 1);
                nc[i][k] = c;
                if (ce && ld[k]) nc[i][k] = int'(ldata[k*W +: W]);
                else if (moves && !hit) nc[i][k] = (c + delta) % 16;
                else if (moves) begin
                    case (mode_of(i))
                        0: nc[i][k] = up[k] ? 0 : mx;
                        1: nc[i][k] = c;
                        2: nc[i][k] = (c + delta) % 16;
                        default: nc[i][k] = int'(ldata[k*W +: W]);
                    endcase
                end
                nw[i][k] = fired;
                no[i][k] = fired || (m_ov[i][k] && !oclr[k]);
                prev_term = fired;
            end
        end
        @(posedge clk);
        m_cnt = nc;
        m_wp  = nw;
        m_ov  = no;
        #1;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #2;
        clear_n = 1'b1;
        model_clear();
    endtask

    task automatic idle_inputs();
        ce = 1'b1; en = '0; up = '1; ld = '0; oclr = '0; ldata = '0; maxv = '1;
    endtask

    task automatic test_reset();
        idle_inputs();
        up = 4'b0101;
        maxv = {4'd0, 4'd7, 4'd3, 4'd0};
        clear_n = 1'b0;
        model_clear();
        #3;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (cv[i] !== '0 || wp[i] !== '0 || ov[i] !== '0) begin
                n_err++;
                $display("FAIL reset inst%0d: cv=%h wp=%b ov=%b, required all zero", i, cv[i], wp[i], ov[i]);
            end
            n_vec++;
            if (co[i] !== 4'b1011) begin
                n_err++;
                $display("FAIL reset_compare inst%0d: got %b, required 1011", i, co[i]);
            end
        end
        clear_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        do_reset();
        idle_inputs();
        maxv = {4{4'd9}};
        en = 4'b0001;
        for (int t = 0; t < 12; t++) begin
            int e = (t < 9) ? t + 1 : t - 9;
            cycle();
            n_vec++;
            if (got_cnt(0, 0) !== e || wp[0][0] !== (t == 9) || ov[0][0] !== (t >= 9)) begin
                n_err++;
                $display("FAIL wrap t=%0d: cnt=%0d wp=%b ov=%b, required cnt=%0d wp=%b ov=%b",
                         t, got_cnt(0, 0), wp[0][0], ov[0][0], e, t == 9, t >= 9);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        idle_inputs();
        ldata = 16'h0003;
        ld = 4'b0001;
        cycle();
        ld = '0;
        up = '0;
        en = 4'b0001;
        for (int t = 0; t < 6; t++) begin
            int e = (t < 3) ? 2 - t : 0;
            cycle();
            n_vec++;
            if (got_cnt(1, 0) !== e || wp[1][0] !== 1'b0 || ov[1][0] !== 1'b0) begin
                n_err++;
                $display("FAIL halt t=%0d: cnt=%0d wp=%b ov=%b, required cnt=%0d wp=0 ov=0",
                         t, got_cnt(1, 0), wp[1][0], ov[1][0], e);
            end
        end
        n_vec++;
        if (co[1][0] !== 1'b1) begin
            n_err++;
            $display("FAIL halt_compare: got %b, required 1", co[1][0]);
        end
    endtask

    task automatic test_reload();
        do_reset();
        idle_inputs();
        ldata = 16'h0005;
        maxv = 16'h0007;
        ld = 4'b0001;
        en = '0;
        cycle();
        n_vec++;
        if (got_cnt(3, 0) !== 5) begin
            n_err++;
            $display("FAIL reload_load_disabled: got %0d, required 5", got_cnt(3, 0));
        end
        ld = '0;
        en = 4'b0001;
        for (int t = 0; t < 6; t++) begin
            int e = 5 + (t + 1) % 3;
            cycle();
            n_vec++;
            if (got_cnt(3, 0) !== e) begin
                n_err++;
                $display("FAIL reload t=%0d: got %0d, required %0d", t, got_cnt(3, 0), e);
            end
        end
    endtask

    task automatic test_cascade();
        int p0 = 0;
        int p1 = 0;
        do_reset();
        idle_inputs();
        maxv = {4{4'd9}};
        en = 4'b0011;
        for (int t = 0; t < 100; t++) begin
            cycle();
            p0 += int'(wp[4][0]);
            p1 += int'(wp[4][1]);
        end
        n_vec++;
        if (got_cnt(4, 0) !== 0 || got_cnt(4, 1) !== 0 || p0 !== 10 || p1 !== 1) begin
            n_err++;
            $display("FAIL cascade: ch0=%0d ch1=%0d pulses0=%0d pulses1=%0d, required 0 0 10 1",
                     got_cnt(4, 0), got_cnt(4, 1), p0, p1);
        end
    endtask

    task automatic test_ovf_clr();
        do_reset();
        idle_inputs();
        maxv = 16'h0002;
        en = 4'b0001;
        cycle();
        cycle();
        oclr = 4'b0001;
        cycle();
        n_vec++;
        if (ov[0][0] !== 1'b1 || got_cnt(0, 0) !== 0) begin
            n_err++;
            $display("FAIL ovf_set_wins: ov=%b cnt=%0d, required ov=1 cnt=0", ov[0][0], got_cnt(0, 0));
        end
        en = '0;
        cycle();
        n_vec++;
        if (ov[0][0] !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b, required 0", ov[0][0]);
        end
    endtask

    task automatic test_async_clear();
        do_reset();
        idle_inputs();
        maxv = '1;
        en = 4'b0001;
        repeat (6) cycle();
        n_vec++;
        if (got_cnt(0, 0) !== 6) begin
            n_err++;
            $display("FAIL async_precount: got %0d, required 6", got_cnt(0, 0));
        end
        #2 clear_n = 1'b0;
        #2;
        n_vec++;
        if (got_cnt(0, 0) !== 0 || ov[0] !== '0 || wp[0] !== '0) begin
            n_err++;
            $display("FAIL async_clear: cnt=%0d, required 0 before next edge", got_cnt(0, 0));
        end
        model_clear();
        #1 clear_n = 1'b1;
        cycle();
        n_vec++;
        if (got_cnt(0, 0) !== 1) begin
            n_err++;
            $display("FAIL async_resume: got %0d, required 1", got_cnt(0, 0));
        end
    endtask

    task automatic test_random();
        do_reset();
        idle_inputs();
        for (int t = 0; t < 400; t++) begin
            ce   = ($urandom_range(0, 3) != 0);
            en   = 4'($urandom) | 4'($urandom);
            if ($urandom_range(0, 7) == 0) up = 4'($urandom);
            ld   = ce ? (4'($urandom) & 4'($urandom) & 4'($urandom)) : '0;
            oclr = 4'($urandom) & 4'($urandom);
            ldata = 16'($urandom);
            if ($urandom_range(0, 15) == 0) maxv = 16'($urandom);
            cycle();
            for (int i = 0; i < NI; i++)
                for (int k = 0; k < CH; k++) begin
                    n_vec++;
                    if (got_cnt(i, k) !== m_cnt[i][k] || wp[i][k] !== m_wp[i][k] ||
                        ov[i][k] !== m_ov[i][k] || co[i][k] !== exp_cmp(i, k)) begin
                        n_err++;
                        $display("FAIL random t=%0d inst%0d ch%0d: cnt=%0d wp=%b ov=%b co=%b, required cnt=%0d wp=%b ov=%b co=%b",
                                 t, i, k, got_cnt(i, k), wp[i][k], ov[i][k], co[i][k],
                                 m_cnt[i][k], m_wp[i][k], m_ov[i][k], exp_cmp(i, k));
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_halt();
        test_reload();
        test_cascade();
        test_ovf_clr();
        test_async_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logisim_counter_bank.md
LOGISIM_COUNTER_BANK -- requirements
Module: logisim_counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bits per channel counter.
REQ-002 SHALL have parameter CHANNELS, default 4, giving the number of independent counter channels.
REQ-003 SHALL have parameter MODE, default 0, giving the terminal behaviour for all channels: 0 wrap, 1 halt, 2 continue, 3 reload.
REQ-004 SHALL have parameter CASCADE, default 0; when 1, each channel k>0 advances only on channel k-1's terminal event.
REQ-005 SHALL have port GlobalClock, in, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port clear_n, in, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port ClockEnable, in, 1 bit: global tick qualifier for all channels.
REQ-008 SHALL have port Enable, in, CHANNELS bits: per-channel count enable.
REQ-009 SHALL have port Up_n_Down, in, CHANNELS bits: per-channel direction, 1 up and 0 down.
REQ-010 SHALL have port load, in, CHANNELS bits: per-channel synchronous load.
REQ-011 SHALL have port LoadData, in, CHANNELS*WIDTH bits: per-channel load/reload value, with channel k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port MaxVal, in, CHANNELS*WIDTH bits: per-channel runtime terminal value for counting up, same packing as LoadData.
REQ-013 SHALL have port ovf_clr, in, CHANNELS bits: per-channel synchronous clear of Overflow.
REQ-014 SHALL have port CountValue, out, CHANNELS*WIDTH bits: registered counter values, same packing as LoadData.
REQ-015 SHALL have port CompareOut, out, CHANNELS bits: combinational terminal flag per channel.
REQ-016 SHALL have port WrapPulse, out, CHANNELS bits: registered one-cycle pulse per channel on each terminal event.
REQ-017 SHALL have port Overflow, out, CHANNELS bits: sticky registered terminal-event flag per channel.

Function
REQ-018 CompareOut[k] SHALL be (CountValue[k]==MaxVal[k]) when Up_n_Down[k]=1, else (CountValue[k]==0).
REQ-019 Effective enable en[k] SHALL be Enable[k] for k=0 or CASCADE=0, else Enable[k] & term[k-1], computed combinationally in the same cycle.
REQ-020 Advance adv[k] SHALL be ClockEnable & en[k] & ~load[k].
REQ-021 Terminal event term[k] SHALL be adv[k] & CompareOut[k], forced to 0 when MODE=1.
REQ-022 Update priority SHALL be clear_n low, then load, then advance, then hold.
REQ-023 load[k]=1 with ClockEnable=1 SHALL set CountValue[k]=LoadData[k] regardless of Enable and cascade, with no WrapPulse and no Overflow change.
REQ-024 When adv[k]=1 and CompareOut[k]=0, CountValue[k] SHALL increment (up) or decrement (down) by 1 modulo 2^WIDTH.
REQ-025 When adv[k]=1 and CompareOut[k]=1 in MODE 0, the next value SHALL be 0 when counting up and MaxVal[k] when counting down.
REQ-026 When adv[k]=1 and CompareOut[k]=1 in MODE 1, the value SHALL hold (halt at terminal).
REQ-027 When adv[k]=1 and CompareOut[k]=1 in MODE 2, the value SHALL step by ±1 modulo 2^WIDTH, ignoring MaxVal for the next-value calculation.
REQ-028 When adv[k]=1 and CompareOut[k]=1 in MODE 3, the next value SHALL be LoadData[k].
REQ-029 When counting up with CountValue>MaxVal (MaxVal changed at runtime), the counter SHALL continue to 2^WIDTH-1, wrap to 0, then match normally; there is no early terminal.
REQ-030 WrapPulse[k] SHALL be 1 for exactly the cycle following each term[k]=1 and 0 otherwise; back-to-back terminal events SHALL give back-to-back pulses.
REQ-031 Overflow[k] SHALL set on term[k] and clear on ovf_clr[k]; when both occur in the same cycle, set SHALL win.
REQ-032 Changing Up_n_Down[k] SHALL take effect on the next advance with no extra latency.
REQ-033 Channels SHALL be fully independent except for the cascade enable path.

Reset
REQ-034 clear_n=0 SHALL immediately, without waiting for a clock edge, force CountValue=0, WrapPulse=0 and Overflow=0 for all channels, including mid-count and mid-pulse.
REQ-035 During reset, CompareOut SHALL still follow REQ-018 on the reset values.
REQ-036 The first rising edge after clear_n rises SHALL apply normal update rules.

Verification
REQ-037 With WIDTH=4, MODE=0, MaxVal=9, counting up and enabled for 12 ticks, CountValue SHALL go 1..9,0,1,2, with WrapPulse high in the cycle following the 9->0 edge and Overflow=1.
REQ-038 With MODE=1, counting down from LoadData=3, CountValue SHALL go 2,1,0 and then hold 0 with CompareOut=1, WrapPulse never asserted and Overflow=0.
REQ-039 With MODE=3, LoadData=5, MaxVal=7, counting up, the sequence SHALL be 6,7,5,6,7,5; asserting load=1 together with Enable=0 SHALL still load 5.
REQ-040 With CASCADE=1, channels 0 and 1 at MaxVal=9 (two BCD digits) and 100 ticks, the result SHALL be ch1=0 and ch0=0, with exactly 1 WrapPulse on ch1 and 10 on ch0.
REQ-041 With ovf_clr asserted in the same cycle as a terminal event, Overflow SHALL remain 1; ovf_clr alone on the next cycle SHALL clear it to 0.
REQ-042 With clear_n pulsed low between clock edges while CountValue=6, CountValue SHALL read 0 before the next edge, and counting SHALL resume at 1 after release.
